// File: rtl/axi_write_responder.sv
// AXI write-path subordinate endpoint: one AW burst at a time, each W beat
// becomes a single-beat req/gnt memory write, one B response per burst.
module axi_write_responder #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [ID_WIDTH-1:0]     aw_id_i,
   input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
   input  logic [7:0]              aw_len_i,
   input  logic [2:0]              aw_size_i,
   input  logic [1:0]              aw_burst_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   input  logic [DATA_WIDTH-1:0]   w_data_i,
   input  logic [DATA_WIDTH/8-1:0] w_strb_i,
   input  logic                    w_last_i,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   output logic [ID_WIDTH-1:0]     b_id_o,
   output logic [1:0]              b_resp_o,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o
);

   localparam int          STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [2:0]  MAX_SIZE   = 3'($clog2(STRB_WIDTH));
   localparam logic [1:0]  BURST_INCR = 2'b01;
   localparam logic [1:0]  BURST_WRAP = 2'b10;
   localparam logic [1:0]  BURST_RSVD = 2'b11;

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [7:0]            cnt_q;
   logic                  err_q;

   logic                  aw_hs, w_hs, b_hs;
   logic [ADDR_WIDTH-1:0] step;

   assign aw_hs = aw_valid_i & aw_ready_o;
   assign w_hs  = w_valid_i & w_ready_o;
   assign b_hs  = b_valid_o & b_ready_i;
   assign step  = ADDR_WIDTH'(1) << size_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (aw_hs)             state_d = DATA;
         DATA:    if (w_hs && w_last_i)  state_d = RESP;
         RESP:    if (b_hs)              state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   // Handshake outputs are gated by rst_ni so they read 0 throughout reset.
   always_comb begin
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      mem_req_o  = 1'b0;
      case (state_q)
         IDLE: aw_ready_o = rst_ni;
         DATA: begin
            mem_req_o = rst_ni & w_valid_i & ~err_q;
            w_ready_o = rst_ni & (err_q | mem_gnt_i);
         end
         RESP: b_valid_o = rst_ni;
         default: ;
      endcase
   end

   assign b_id_o      = id_q;
   assign b_resp_o    = {err_q, 1'b0};
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = w_data_i;
   assign mem_be_o    = w_strb_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (aw_hs) begin
            id_q    <= aw_id_i;
            addr_q  <= aw_addr_i;
            len_q   <= aw_len_i;
            size_q  <= aw_size_i;
            burst_q <= aw_burst_i;
            cnt_q   <= '0;
            err_q   <= (aw_burst_i == BURST_WRAP) || (aw_burst_i == BURST_RSVD) ||
                       (aw_size_i > MAX_SIZE);
         end
         if (w_hs) begin
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            // The err register only gates later beats; the mismatching beat is still written.
            if (w_last_i != (cnt_q == len_q)) err_q <= 1'b1;
            if (burst_q == BURST_INCR) addr_q <= (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
         end
      end
   end

endmodule

// File: tb/tb_axi_write_responder.sv
// Directed bench for axi_write_responder: burst table plus hand-written
// backpressure and mid-burst reset sequences.
module tb_axi_write_responder;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        aw_valid, aw_ready;
   logic [3:0]  aw_id;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        w_valid, w_ready;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        mem_req, mem_gnt;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi_write_responder #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
      .aw_len_i(aw_len), .aw_size_i(aw_size), .aw_burst_i(aw_burst),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
      .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be)
   );

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          nbeats;
      int          last_pos;
      int          nwr;
      logic [31:0] ea [4];
      logic [1:0]  resp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                               input int last_pos, input int nwr, input logic [31:0] a0,
                               input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3,
                               input logic [1:0] resp);
      vec_t v;
      v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
      v.nbeats = nbeats; v.last_pos = last_pos; v.nwr = nwr;
      v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
      v.resp = resp;
      return v;
   endfunction

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      @(negedge clk);
      aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
      #1 chk("aw_ready_idle", aw_ready, 1);
      @(posedge clk);
      @(negedge clk);
      aw_valid = 1'b0;
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int k;
      send_aw(v.id, v.addr, v.len, v.size, v.burst);
      #1 chk("aw_ready_data", aw_ready, 0);
      k = 0;
      for (int b = 0; b < v.nbeats; b++) begin
         if (b > 0) @(negedge clk);
         w_valid = 1'b1;
         w_data  = 64'h1111_0000_0000_0000 * 64'(b + 1) + 64'(vi);
         w_strb  = 8'hF0 ^ 8'(b);
         w_last  = (b == v.last_pos);
         #1 chk($sformatf("v%0d_b%0d_wready", vi, b), w_ready, 1);
         if (mem_req) begin
            if (k < 4) chk($sformatf("v%0d_b%0d_addr", vi, b), mem_addr, v.ea[k]);
            chk($sformatf("v%0d_b%0d_wdata", vi, b), mem_wdata, w_data);
            chk($sformatf("v%0d_b%0d_be", vi, b), mem_be, w_strb);
            k++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      w_valid = 1'b0; w_last = 1'b0;
      #1;
      chk($sformatf("v%0d_nwr", vi), k, v.nwr);
      chk($sformatf("v%0d_bvalid", vi), b_valid, 1);
      chk($sformatf("v%0d_bid", vi), b_id, v.id);
      chk($sformatf("v%0d_bresp", vi), b_resp, v.resp);
      chk($sformatf("v%0d_wready_resp", vi), w_ready, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_aw_ready_after_b", vi), aw_ready, 1);
      chk($sformatf("v%0d_bvalid_drop", vi), b_valid, 0);
   endtask

   initial begin
      vecs[0] = mk(4'h3, 32'h100,  8'd0, 3'd3, 2'b01, 1, 0, 1, 32'h100, 0, 0, 0, 2'b00);
      vecs[1] = mk(4'h5, 32'h104,  8'd3, 3'd3, 2'b01, 4, 3, 4, 32'h104, 32'h108, 32'h110, 32'h118, 2'b00);
      vecs[2] = mk(4'h1, 32'h40,   8'd2, 3'd3, 2'b00, 3, 2, 3, 32'h40, 32'h40, 32'h40, 0, 2'b00);
      vecs[3] = mk(4'h7, 32'h80,   8'd1, 3'd3, 2'b10, 2, 1, 0, 0, 0, 0, 0, 2'b10);
      vecs[4] = mk(4'h2, 32'h0,    8'd1, 3'd4, 2'b01, 2, 1, 0, 0, 0, 0, 0, 2'b10);
      vecs[5] = mk(4'h4, 32'h200,  8'd3, 3'd3, 2'b01, 2, 1, 2, 32'h200, 32'h208, 0, 0, 2'b10);
      vecs[6] = mk(4'h6, 32'h300,  8'd0, 3'd3, 2'b01, 3, 2, 1, 32'h300, 0, 0, 0, 2'b10);
      vecs[7] = mk(4'hA, 32'h1002, 8'd2, 3'd2, 2'b01, 3, 2, 3, 32'h1002, 32'h1004, 32'h1008, 0, 2'b00);

      rst_ni = 1'b0; aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0;
      aw_burst = '0; w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
      b_ready = 1'b1; mem_gnt = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_b_id", b_id, 0);
      chk("rst_b_resp", b_resp, 0);
      rst_ni = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Memory grant stall, then B backpressure.
      send_aw(4'hC, 32'h500, 8'd1, 3'd3, 2'b01);
      mem_gnt = 1'b0; w_valid = 1'b1; w_data = 64'hDEAD_BEEF_0000_0001; w_strb = 8'hFF; w_last = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall%0d_wready", c), w_ready, 0);
         chk($sformatf("stall%0d_req", c), mem_req, 1);
         chk($sformatf("stall%0d_addr", c), mem_addr, 32'h500);
         @(posedge clk);
         @(negedge clk);
      end
      mem_gnt = 1'b1;
      #1 chk("stall_release_wready", w_ready, 1);
      @(posedge clk);
      @(negedge clk);
      w_data = 64'hDEAD_BEEF_0000_0002; w_last = 1'b1;
      #1 chk("stall_beat1_addr", mem_addr, 32'h508);
      @(posedge clk);
      @(negedge clk);
      w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("bhold%0d_valid", c), b_valid, 1);
         chk($sformatf("bhold%0d_id", c), b_id, 4'hC);
         chk($sformatf("bhold%0d_resp", c), b_resp, 2'b00);
         @(posedge clk);
         @(negedge clk);
      end
      b_ready = 1'b1;
      #1 chk("bhold_final_valid", b_valid, 1);
      @(posedge clk);
      @(negedge clk);
      #1 chk("bhold_aw_ready", aw_ready, 1);

      // Reset in the middle of a burst.
      send_aw(4'h9, 32'h600, 8'd3, 3'd3, 2'b01);
      w_valid = 1'b1; w_data = 64'h5; w_strb = 8'h0F; w_last = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_wready", w_ready, 0);
      chk("mid_rst_aw_ready", aw_ready, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("mid_rst_addr", mem_addr, 0);
      chk("mid_rst_bid", b_id, 0);
      rst_ni = 1'b1; w_valid = 1'b0;
      #1 chk("post_rst_aw_ready", aw_ready, 1);
      @(posedge clk);
      @(negedge clk);
      #1 chk("post_rst_bvalid", b_valid, 0);

      run_vec(0, vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
